// File: rtl/lcd_sched_pkg.sv
// Shared types and LCD command constants for the character-LCD line scheduler.
package lcd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_FIN  = 2'd3
    } sched_state_e;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_LINE2_OFFSET  = 8'h40;
    localparam logic       LCD_ADDR_CMD      = 1'b0;
    localparam logic       LCD_ADDR_DATA     = 1'b1;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-source round-robin pick; the last-served register moves only when a transfer finishes.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       fin,
    input  logic       served,
    output logic       pick
);

    logic last_q;

    // Reset to 1 so that source 0 wins the very first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (fin) begin
            last_q <= served;
        end
    end

    always_comb begin
        pick = (req == 2'b11) ? ~last_q : req[1];
    end

endmodule

// File: rtl/lcd_line_scheduler.sv
// Shares the LCD controller's Avalon-MM slave between two line-writing sources.
// Optional stall watchdog is built when LCD_SCHED_TIMEOUT_EN is defined.
module lcd_line_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int LINE_CHARS     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [1:0]  req_line,
    input  logic [15:0] req_char,
    output logic [1:0]  grant,
    output logic [3:0]  char_idx,
    output logic [1:0]  done,
    output logic        busy,
    output logic        err,
    output logic        address,
    output logic        chipselect,
    output logic        write,
    output logic [7:0]  writedata,
    input  logic        waitrequest,
    output logic [1:0]  state_dbg
);

    // Avalon write handshake: a beat is offered with chipselect=write=1 and is
    // taken on the rising edge where waitrequest=0; address and writedata hold
    // unchanged until that edge.

    if (LINE_CHARS < 1 || LINE_CHARS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("lcd_line_scheduler: LINE_CHARS must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [3:0] LAST_IDX = 4'(LINE_CHARS - 1);

    sched_state_e state, state_n;
    logic [1:0]   grant_q;
    logic         owner_q;
    logic         line_q;
    logic [3:0]   idx_q;
    logic         pick;

    lcd_rr_arbiter u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .fin     (state == ST_FIN),
        .served  (owner_q),
        .pick    (pick)
    );

`ifdef LCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] stall_cnt;
    logic             abort_q;
    logic             stalled;
    logic             timeout_hit;

    assign stalled     = ((state == ST_CMD) || (state == ST_DATA)) && waitrequest;
    assign timeout_hit = stalled && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            stall_cnt <= (stalled && !timeout_hit) ? stall_cnt + 1'b1 : '0;
            abort_q   <= timeout_hit;
        end
    end

    // abort_q is high only in the FIN cycle that follows a watchdog hit.
    assign err = abort_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
            owner_q <= 1'b0;
            line_q  <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= pick ? 2'b10 : 2'b01;
                        owner_q <= pick;
                        line_q  <= req_line[pick];
                        idx_q   <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (!waitrequest && (idx_q != LAST_IDX)) begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_FIN: begin
                    grant_q <= 2'b00;
                    idx_q   <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        address    = LCD_ADDR_CMD;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 8'h00;
        done       = 2'b00;
        case (state)
            ST_IDLE: begin
                if (|req) state_n = ST_CMD;
            end
            ST_CMD: begin
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = LCD_CMD_SET_DDRAM | (line_q ? LCD_LINE2_OFFSET : 8'h00);
                if (!waitrequest) state_n = ST_DATA;
            end
            ST_DATA: begin
                address    = LCD_ADDR_DATA;
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = owner_q ? req_char[15:8] : req_char[7:0];
                if (!waitrequest && (idx_q == LAST_IDX)) state_n = ST_FIN;
            end
            ST_FIN: begin
                done    = grant_q;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef LCD_SCHED_TIMEOUT_EN
        if (timeout_hit) state_n = ST_FIN;
`endif
    end

    assign grant     = grant_q;
    assign char_idx  = idx_q;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule
